qspi_responder: RTL and testbench

QSPI_RESPONDER -- requirements
Module: qspi_responder

---
 rtl/qspi_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_qspi_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_responder.sv
// QSPI read-only responder: Reset / PowerUp / quad Read (0xEB) with byte prefetch.
// Define QSPI_RESP_WRAP_EN to wrap reads inside an aligned 32-byte window.
module qspi_responder #(
    parameter int ADDR_W       = 24,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic              io_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              powered_up,
    output logic              underrun
);
    localparam logic [7:0] OP_RESET = 8'h99;
    localparam logic [7:0] OP_PWRUP = 8'hAB;
    localparam logic [7:0] OP_READ  = 8'hEB;
    localparam int CW = 8;
    localparam logic [CW-1:0] CMD_LAST   = CW'(7);
    localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_W / 4 - 1);
    localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

    state_t            state;
    logic [2:0]        sclk_sync;
    logic [2:0]        cs_sync;
    logic [3:0]        io_s1;
    logic [3:0]        io_s2;
    logic [1:0]        settle;
    logic              cs_ok;
    logic [CW-1:0]     cnt;
    logic [6:0]        cmd_sh;
    logic [ADDR_W-5:0] addr_sh;
    logic [ADDR_W-1:0] nxt_addr;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        buf_q;
    logic [7:0]        cur_q;
    logic              buf_valid;
    logic              cur_ok;
    logic              lo;
    logic              armed;
    logic              pend;
    logic              stale;

    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_rise;
    logic              cs_fall;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] addr_full;
    logic              ack_live;
    logic              hit_nxt;
    logic              hit_cur;
    logic [7:0]        nbyte;
    logic [7:0]        cbyte;
    logic              adv;

    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
`ifdef QSPI_RESP_WRAP_EN
        return {a[ADDR_W-1:5], a[4:0] + 5'd1};
`else
        return a + ADDR_W'(1);
`endif
    endfunction

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2] & cs_ok;
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign opcode    = {cmd_sh, io_s2[0]};
    assign addr_full = {addr_sh, io_s2};
    assign ack_live  = mem_req & mem_ack & ~stale;
    assign hit_nxt   = ack_live && (mem_addr == nxt_addr);
    assign hit_cur   = ack_live && (mem_addr == cur_addr);
    assign nbyte     = buf_valid ? buf_q : mem_rdata;
    assign cbyte     = cur_ok ? cur_q : mem_rdata;
    assign adv       = (state == DUMMY && sclk_rise && cnt == DUMMY_LAST)
                     || (state == DATA && sclk_fall && armed);

    // Bring sclk, cs and the data lines into the clk domain with equal delay;
    // cs is only trusted once it has been seen low after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            io_s1     <= '0;
            io_s2     <= '0;
            settle    <= '0;
            cs_ok     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[1:0], cs};
            io_s1     <= io_in;
            io_s2     <= io_s1;
            settle    <= {settle[0], 1'b1};
            if (settle[1] && !cs_sync[1])
                cs_ok <= 1'b1;
        end
    end

    // Transaction FSM, fetch tracking and nibble output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            io_out     <= '0;
            io_oe      <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            powered_up <= 1'b0;
            underrun   <= 1'b0;
            cnt        <= '0;
            cmd_sh     <= '0;
            addr_sh    <= '0;
            nxt_addr   <= '0;
            cur_addr   <= '0;
            buf_q      <= '0;
            cur_q      <= '0;
            buf_valid  <= 1'b0;
            cur_ok     <= 1'b0;
            lo         <= 1'b0;
            armed      <= 1'b0;
            pend       <= 1'b0;
            stale      <= 1'b0;
        end else begin
            if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
                stale   <= 1'b0;
                if (hit_nxt) begin
                    buf_q     <= mem_rdata;
                    buf_valid <= 1'b1;
                end else if (hit_cur) begin
                    cur_q  <= mem_rdata;
                    cur_ok <= 1'b1;
                end
            end else if (!mem_req && pend) begin
                mem_req  <= 1'b1;
                mem_addr <= nxt_addr;
                pend     <= 1'b0;
            end

            if (cs_fall) begin
                state     <= IDLE;
                io_oe     <= 1'b0;
                io_out    <= '0;
                pend      <= 1'b0;
                buf_valid <= 1'b0;
                cur_ok    <= 1'b0;
                if (mem_req && !mem_ack)
                    stale <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cs_rise) begin
                            state    <= CMD;
                            cnt      <= '0;
                            underrun <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sh <= opcode[6:0];
                            cnt    <= cnt + CW'(1);
                            if (cnt == CMD_LAST) begin
                                cnt   <= '0;
                                state <= IGNORE;
                                case (opcode)
                                    OP_RESET: powered_up <= 1'b0;
                                    OP_PWRUP: powered_up <= 1'b1;
                                    OP_READ:  if (powered_up) state <= ADDR;
                                    default:  state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr_sh <= addr_full[ADDR_W-5:0];
                            cnt     <= cnt + CW'(1);
                            if (cnt == ADDR_LAST) begin
                                cnt       <= '0;
                                state     <= DUMMY;
                                nxt_addr  <= addr_full;
                                buf_valid <= 1'b0;
                                cur_ok    <= 1'b0;
                                lo        <= 1'b0;
                                armed     <= 1'b0;
                                if (mem_req) begin
                                    pend <= 1'b1;
                                end else begin
                                    mem_req  <= 1'b1;
                                    mem_addr <= addr_full;
                                end
                            end
                        end
                    end
                    DUMMY: begin
                        if (sclk_rise) begin
                            cnt <= cnt + CW'(1);
                            if (cnt == DUMMY_LAST) begin
                                cnt   <= '0;
                                state <= DATA;
                                io_oe <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise)
                            armed <= 1'b1;
                        else if (sclk_fall)
                            armed <= 1'b0;
                    end
                    IGNORE: begin
                    end
                    default: state <= IDLE;
                endcase

                if (adv) begin
                    if (!lo) begin
                        lo       <= 1'b1;
                        cur_addr <= nxt_addr;
                        nxt_addr <= inc(nxt_addr);
                        if (buf_valid || hit_nxt) begin
                            io_out    <= nbyte[7:4];
                            cur_q     <= nbyte;
                            cur_ok    <= 1'b1;
                            buf_valid <= 1'b0;
                        end else begin
                            io_out   <= 4'h0;
                            underrun <= 1'b1;
                            cur_ok   <= 1'b0;
                        end
                        if (mem_req) begin
                            pend <= 1'b1;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= inc(nxt_addr);
                        end
                    end else begin
                        lo <= 1'b0;
                        if (cur_ok || hit_cur) begin
                            io_out <= cbyte[3:0];
                        end else begin
                            io_out   <= 4'h0;
                            underrun <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_qspi_responder.sv
// Bench for qspi_responder: bit-banged QSPI initiator, latency-programmable
// backing store and a byte-stream reference model.
module tb_qspi_responder;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sclk = 1'b0;
    logic          cs = 1'b0;
    logic [3:0]    io_in = 4'h0;
    logic [3:0]    io_out;
    logic          io_oe;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_rdata = 8'h00;
    logic          powered_up;
    logic          underrun;

    qspi_responder #(.ADDR_W(AW), .DUMMY_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs),
        .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .powered_up(powered_up), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int            nvec = 0;
    int            nerr = 0;
    int            lat = 2;
    logic [7:0]    key = 8'h00;
    logic [AW-1:0] alog[$];
    int            oe_cnt = 0;
    int            req_cnt = 0;
    int            wcnt = 0;
    logic [3:0]    got[$];
    logic          oe_all;

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ key;
    endfunction

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
`ifdef QSPI_RESP_WRAP_EN
        return (a & ~AW'(32'h1F)) | (AW'(a + 1) & AW'(32'h1F));
`else
        return AW'(a + 1);
`endif
    endfunction

    // backing store: ack after lat cycles, log every fetched address
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (io_oe) oe_cnt++;
        if (mem_req) begin
            req_cnt++;
            wcnt++;
            if (wcnt >= lat) begin
                mem_ack = 1'b1;
                mem_rdata = mem_byte(mem_addr);
                alog.push_back(mem_addr);
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] d, output logic [3:0] q,
                       output logic oe);
        io_in = d;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        q = io_out;
        oe = io_oe;
        sclk = 1'b0;
    endtask

    task automatic cs_on();
        cs = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_off(input int hold);
        io_in = 4'h0;
        repeat (2) @(negedge clk);
        cs = 1'b0;
        repeat (hold) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] op, input int n);
        logic [3:0] q;
        logic oe;
        for (int i = 0; i < n; i++) cyc({3'b000, op[7-i]}, q, oe);
    endtask

    task automatic send_op(input logic [7:0] op);
        cs_on();
        send_bits(op, 8);
        cs_off(8);
    endtask

    // Read command up to the last data nibble; cs is left high.
    task automatic read_body(input logic [AW-1:0] a, input int nbytes);
        logic [3:0] q;
        logic oe;
        cs_on();
        send_bits(8'hEB, 8);
        for (int i = 0; i < AW / 4; i++) cyc(a[AW-1-4*i -: 4], q, oe);
        for (int i = 0; i < 4; i++) cyc(4'h0, q, oe);
        got.delete();
        oe_all = 1'b1;
        for (int i = 0; i < 2 * nbytes; i++) begin
            cyc(4'h0, q, oe);
            got.push_back(q);
            oe_all = oe_all & oe;
        end
    endtask

    task automatic check_read(input string tag, input logic [AW-1:0] a,
                              input int nbytes);
        int base;
        logic [AW-1:0] ea;
        logic [7:0] b;
        base = alog.size();
        read_body(a, nbytes);
        cs_off(8);
        chk({tag, "_oe"}, 32'(oe_all), 32'd1);
        chk({tag, "_undr"}, 32'(underrun), 32'd0);
        chk({tag, "_oe_off"}, 32'(io_oe), 32'd0);
        ea = a;
        for (int k = 0; k < nbytes; k++) begin
            b = mem_byte(ea);
            chk($sformatf("%s_hi%0d", tag, k), 32'(got[2*k]), 32'(b[7:4]));
            chk($sformatf("%s_lo%0d", tag, k), 32'(got[2*k+1]), 32'(b[3:0]));
            chk($sformatf("%s_addr%0d", tag, k),
                (base + k < alog.size()) ? 32'(alog[base+k]) : 32'hxxxxxxxx,
                32'(ea));
            ea = nxt(ea);
        end
    endtask

    initial begin
        int o0;
        int r0;
        logic [AW-1:0] ra;
        int rn;
        repeat (3) @(negedge clk);
        chk("rst_oe", 32'(io_oe), 32'd0);
        chk("rst_io", 32'(io_out), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_pwr", 32'(powered_up), 32'd0);
        chk("rst_undr", 32'(underrun), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Read before PowerUp is ignored
        o0 = oe_cnt;
        r0 = req_cnt;
        read_body(AW'(32'h10), 2);
        cs_off(8);
        chk("nopwr_oe", 32'(oe_cnt), 32'(o0));
        chk("nopwr_req", 32'(req_cnt), 32'(r0));
        chk("nopwr_pwr", 32'(powered_up), 32'd0);

        send_op(8'hAB);
        chk("pwrup", 32'(powered_up), 32'd1);

        key = 8'h00;
        check_read("r10", AW'(32'h10), 3);
        check_read("rtop", AW'(32'hFFFFFF), 2);

        // truncated Reset command must be dropped
        cs_on();
        send_bits(8'h99, 5);
        cs_off(8);
        chk("partial_pwr", 32'(powered_up), 32'd1);
        key = 8'h5A;
        check_read("rpart", AW'(32'h001234), 2);

        for (int i = 0; i < 4; i++) begin
            key = 8'($urandom);
            ra = AW'($urandom);
            rn = $urandom_range(1, 4);
            check_read($sformatf("rnd%0d", i), ra, rn);
        end

        check_read("win", AW'(32'h3F), 3);

        // slow memory: underrun, held fetch across cs fall
        lat = 40;
        read_body(AW'(32'h100), 2);
        for (int k = 0; k < 4; k++)
            chk($sformatf("slow_n%0d", k), 32'(got[k]), 32'd0);
        chk("slow_oe", 32'(oe_all), 32'd1);
        cs_off(3);
        chk("slow_undr", 32'(underrun), 32'd1);
        chk("slow_hold", 32'(mem_req), 32'd1);
        chk("slow_oe_off", 32'(io_oe), 32'd0);
        for (int i = 0; i < 200 && mem_req; i++) @(negedge clk);
        chk("slow_drop", 32'(mem_req), 32'd0);
        chk("slow_sticky", 32'(underrun), 32'd1);
        lat = 2;
        cs_on();
        repeat (2) @(negedge clk);
        chk("undr_clr", 32'(underrun), 32'd0);
        cs_off(8);
        key = 8'hC3;
        check_read("after_slow", AW'(32'h200), 2);

        // reset mid-transaction, then cs held high must not start a command
        cs_on();
        send_bits(8'hEB, 8);
        send_bits(8'h00, 2);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_pwr", 32'(powered_up), 32'd0);
        chk("mid_req", 32'(mem_req), 32'd0);
        chk("mid_oe", 32'(io_oe), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send_bits(8'hAB, 8);
        cs_off(8);
        chk("no_fresh_rise", 32'(powered_up), 32'd0);
        send_op(8'hAB);
        chk("pwr_again", 32'(powered_up), 32'd1);
        key = 8'h77;
        check_read("final", AW'(32'hABCDEF), 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
